// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer slice.
package fetch_pkg;

  localparam int DEF_PC_W    = 9;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  // Major opcode of conditional branches (low seven instruction bits).
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    ISSUE  = 3'd2,
    BRWAIT = 3'd3,
    HALTED = 3'd4
  } fetch_state_t;

  // Next-PC source selection.
  typedef enum logic [2:0] {
    PC_HOLD    = 3'd0,
    PC_ZERO    = 3'd1,
    PC_INC     = 3'd2,
    PC_IPC_INC = 3'd3,
    PC_IPC_OFF = 3'd4
  } pc_sel_t;

  // True when the opcode field marks a conditional branch.
  function automatic logic is_branch(input logic [6:0] opc);
    return (opc == OPC_BRANCH);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Memory, issue and branch-resolve signals between the fetcher and its neighbours.
interface fetch_sequencer_if
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
);
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_ready;
  logic               br_resolve;
  logic               br_taken;
  logic [PC_W-1:0]    br_offset;

  // Fetcher side.
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, br_resolve, br_taken, br_offset
  );

  // Memory / execute side.
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, br_resolve, br_taken, br_offset
  );
endinterface

// File: rtl/fetch_sequencer_pc_next.sv
// Combinational next-PC select; all sums wrap modulo 2^PC_W.
module fetch_pc_next
  import fetch_pkg::*;
#(
  parameter int PC_W = DEF_PC_W
) (
  input  pc_sel_t         sel_i,
  input  logic [PC_W-1:0] pc_i,
  input  logic [PC_W-1:0] instr_pc_i,
  input  logic [PC_W-1:0] offset_i,
  output logic [PC_W-1:0] pc_next_o
);

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  // Pick the PC source; offset is two's complement so a plain add handles negatives.
  always_comb begin
    pc_next_o = pc_i;
    case (sel_i)
      PC_HOLD:    pc_next_o = pc_i;
      PC_ZERO:    pc_next_o = {PC_W{1'b0}};
      PC_INC:     pc_next_o = pc_i + PC_ONE;
      PC_IPC_INC: pc_next_o = instr_pc_i + PC_ONE;
      PC_IPC_OFF: pc_next_o = instr_pc_i + offset_i;
      default:    pc_next_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences single-outstanding imem reads,
// issues each instruction over valid/ready and stalls on branches.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               halt_i,
  fetch_sequencer_if.master  bus,
  output logic               busy_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  fetch_state_t       state_q, state_d;
  pc_sel_t            pc_sel_s;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [CNT_W-1:0]   retired_q, retired_d;
  logic               retire_s;

  // Status outputs are registered copies of the next-state decode.
  logic imem_req_q, instr_valid_q, busy_q, halted_q;

  fetch_pc_next #(.PC_W(PC_W)) u_pc_next (
    .sel_i      (pc_sel_s),
    .pc_i       (pc_q),
    .instr_pc_i (instr_pc_q),
    .offset_i   (bus.br_offset),
    .pc_next_o  (pc_d)
  );

  // Next-state logic; halt outranks every other event while busy.
  always_comb begin
    state_d    = state_q;
    pc_sel_s   = PC_HOLD;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    retire_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          pc_sel_s = PC_ZERO;
          state_d  = FETCH;
        end else begin
          state_d  = IDLE;
        end
      end
      FETCH: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (bus.imem_ack) begin
          instr_d    = bus.imem_rdata;
          instr_pc_d = pc_q;
          state_d    = ISSUE;
        end else begin
          state_d = FETCH;
        end
      end
      ISSUE: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (bus.instr_ready) begin
          retire_s = 1'b1;
          if (is_branch(instr_q[6:0])) begin
            state_d = BRWAIT;
          end else begin
            pc_sel_s = PC_INC;
            state_d  = FETCH;
          end
        end else begin
          state_d = ISSUE;
        end
      end
      BRWAIT: begin
        if (halt_i) begin
          state_d = HALTED;
        end else if (bus.br_resolve) begin
          pc_sel_s = bus.br_taken ? PC_IPC_OFF : PC_IPC_INC;
          state_d  = FETCH;
        end else begin
          state_d = BRWAIT;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Saturating retired-instruction count.
  always_comb begin
    if (retire_s && (retired_q != CNT_MAX)) begin
      retired_d = retired_q + CNT_ONE;
    end else begin
      retired_d = retired_q;
    end
  end

  // State, PC, issue buffer, counter and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= {PC_W{1'b0}};
      instr_q       <= {INSTR_W{1'b0}};
      instr_pc_q    <= {PC_W{1'b0}};
      retired_q     <= {CNT_W{1'b0}};
      imem_req_q    <= 1'b0;
      instr_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      retired_q     <= retired_d;
      imem_req_q    <= (state_d == FETCH);
      instr_valid_q <= (state_d == ISSUE);
      busy_q        <= (state_d == FETCH) || (state_d == ISSUE) || (state_d == BRWAIT);
      halted_q      <= (state_d == HALTED);
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign busy_o          = busy_q;
  assign halted_o        = halted_q;
  assign retired_o       = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed, table-driven bench for fetch_sequencer plus hand sequences for
// halt/ack collision and asynchronous reset in BRWAIT. A second instance with
// a 2-bit retired counter shares all inputs to exercise saturation.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, halt;
  logic        busy, halted, busy2, halted2;
  logic [15:0] retired;
  logic [1:0]  retired2;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if #(.PC_W(9), .INSTR_W(32)) bus ();
  fetch_sequencer_if #(.PC_W(9), .INSTR_W(32)) bus2 ();

  assign bus2.imem_ack    = bus.imem_ack;
  assign bus2.imem_rdata  = bus.imem_rdata;
  assign bus2.instr_ready = bus.instr_ready;
  assign bus2.br_resolve  = bus.br_resolve;
  assign bus2.br_taken    = bus.br_taken;
  assign bus2.br_offset   = bus.br_offset;

  fetch_sequencer #(.PC_W(9), .INSTR_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .start_i(start), .halt_i(halt), .bus(bus.master),
    .busy_o(busy), .halted_o(halted), .retired_o(retired)
  );

  fetch_sequencer #(.PC_W(9), .INSTR_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start_i(start), .halt_i(halt), .bus(bus2.master),
    .busy_o(busy2), .halted_o(halted2), .retired_o(retired2)
  );

  typedef struct {
    logic        st, ack, rdy, res, tkn, hlt;
    logic [31:0] rd;
    logic [8:0]  off;
    logic        e_req, e_vld, e_busy, e_hltd;
    logic [8:0]  e_addr, e_ipc;
    logic [31:0] e_ins;
    logic [15:0] e_ret;
  } vec_t;

  vec_t vt[32];

  function automatic vec_t mk(input logic st, input logic ack, input logic [31:0] rd,
                              input logic rdy, input logic res, input logic tkn,
                              input logic [8:0] off, input logic hlt,
                              input logic e_req, input logic [8:0] e_addr, input logic e_vld,
                              input logic [31:0] e_ins, input logic [8:0] e_ipc,
                              input logic e_busy, input logic e_hltd, input logic [15:0] e_ret);
    vec_t v;
    v.st = st; v.ack = ack; v.rd = rd; v.rdy = rdy; v.res = res; v.tkn = tkn;
    v.off = off; v.hlt = hlt; v.e_req = e_req; v.e_addr = e_addr; v.e_vld = e_vld;
    v.e_ins = e_ins; v.e_ipc = e_ipc; v.e_busy = e_busy; v.e_hltd = e_hltd; v.e_ret = e_ret;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b0;
    bus.br_resolve = 1'b0; bus.br_taken = 1'b0; bus.br_offset = 9'h0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},   {31'h0, bus.imem_req},    32'h0);
    chk({tag, "_addr"},  {23'h0, bus.imem_addr},   32'h0);
    chk({tag, "_valid"}, {31'h0, bus.instr_valid}, 32'h0);
    chk({tag, "_instr"}, bus.instr,                32'h0);
    chk({tag, "_ipc"},   {23'h0, bus.instr_pc},    32'h0);
    chk({tag, "_busy"},  {31'h0, busy},            32'h0);
    chk({tag, "_halted"},{31'h0, halted},          32'h0);
    chk({tag, "_ret"},   {16'h0, retired},         32'h0);
  endtask

  initial begin
    // st ack rdata rdy res tkn off hlt | req addr vld instr ipc busy hltd ret
    vt[0]  = mk(1,0,32'h0,0,0,0,9'h0,0,        1,9'd0,  0,32'h0,       9'd0,  1,0,16'd0);
    vt[1]  = mk(0,0,32'h0,0,0,0,9'h0,0,        1,9'd0,  0,32'h0,       9'd0,  1,0,16'd0);
    vt[2]  = mk(0,1,32'h13,0,0,0,9'h0,0,       0,9'd0,  1,32'h13,      9'd0,  1,0,16'd0);
    vt[3]  = mk(0,0,32'h0,1,0,0,9'h0,0,        1,9'd1,  0,32'h0,       9'd0,  1,0,16'd1);
    vt[4]  = mk(0,1,32'h00100093,0,0,0,9'h0,0, 0,9'd1,  1,32'h00100093,9'd1,  1,0,16'd1);
    for (int i = 5; i <= 9; i++) vt[i] = vt[4];
    vt[5].rd = 32'h0; vt[5].ack = 1'b0;
    for (int i = 6; i <= 9; i++) vt[i] = vt[5];
    vt[10] = mk(0,0,32'h0,1,0,0,9'h0,0,        1,9'd2,  0,32'h0,       9'd0,  1,0,16'd2);
    vt[11] = mk(0,0,32'h0,0,1,1,9'h5,0,        1,9'd2,  0,32'h0,       9'd0,  1,0,16'd2);
    vt[12] = mk(0,1,32'h13,0,0,0,9'h0,0,       0,9'd2,  1,32'h13,      9'd2,  1,0,16'd2);
    vt[13] = mk(0,0,32'h0,1,0,0,9'h0,0,        1,9'd3,  0,32'h0,       9'd0,  1,0,16'd3);
    vt[14] = mk(0,1,32'h13,0,0,0,9'h0,0,       0,9'd3,  1,32'h13,      9'd3,  1,0,16'd3);
    vt[15] = mk(0,0,32'h0,1,0,0,9'h0,0,        1,9'd4,  0,32'h0,       9'd0,  1,0,16'd4);
    vt[16] = mk(0,1,32'h63,0,0,0,9'h0,0,       0,9'd4,  1,32'h63,      9'd4,  1,0,16'd4);
    vt[17] = mk(0,0,32'h0,1,0,0,9'h0,0,        0,9'd4,  0,32'h0,       9'd0,  1,0,16'd5);
    vt[18] = mk(0,0,32'h0,0,0,1,9'h1FC,0,      0,9'd4,  0,32'h0,       9'd0,  1,0,16'd5);
    vt[19] = mk(0,0,32'h0,0,1,0,9'h1FC,0,      1,9'd5,  0,32'h0,       9'd0,  1,0,16'd5);
    vt[20] = mk(0,1,32'h63,0,0,0,9'h0,0,       0,9'd5,  1,32'h63,      9'd5,  1,0,16'd5);
    vt[21] = mk(0,0,32'h0,1,0,0,9'h0,0,        0,9'd5,  0,32'h0,       9'd0,  1,0,16'd6);
    vt[22] = mk(0,0,32'h0,0,1,1,9'h1FA,0,      1,9'd511,0,32'h0,       9'd0,  1,0,16'd6);
    vt[23] = mk(0,1,32'h13,0,0,0,9'h0,0,       0,9'd511,1,32'h13,      9'd511,1,0,16'd6);
    vt[24] = mk(0,0,32'h0,1,0,0,9'h0,0,        1,9'd0,  0,32'h0,       9'd0,  1,0,16'd7);
    vt[25] = mk(0,1,32'h63,0,0,0,9'h0,0,       0,9'd0,  1,32'h63,      9'd0,  1,0,16'd7);
    vt[26] = mk(0,0,32'h0,1,0,0,9'h0,0,        0,9'd0,  0,32'h0,       9'd0,  1,0,16'd8);
    vt[27] = mk(0,0,32'h0,0,1,1,9'h1FC,0,      1,9'd508,0,32'h0,       9'd0,  1,0,16'd8);
    vt[28] = mk(0,1,32'h13,0,0,0,9'h0,0,       0,9'd508,1,32'h13,      9'd508,1,0,16'd8);
    vt[29] = mk(0,0,32'h0,1,0,0,9'h0,1,        0,9'd508,0,32'h0,       9'd0,  0,1,16'd8);
    vt[30] = mk(1,0,32'h0,0,0,0,9'h0,0,        0,9'd508,0,32'h0,       9'd0,  0,1,16'd8);
    vt[31] = mk(0,1,32'h13,1,1,1,9'h3,0,       0,9'd508,0,32'h0,       9'd0,  0,1,16'd8);

    // Reset state.
    idle_inputs();
    rst = 1'b1;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;

    // Table: apply one row per cycle, compare just after the edge.
    for (int i = 0; i < 32; i++) begin
      start = vt[i].st; halt = vt[i].hlt;
      bus.imem_ack = vt[i].ack; bus.imem_rdata = vt[i].rd; bus.instr_ready = vt[i].rdy;
      bus.br_resolve = vt[i].res; bus.br_taken = vt[i].tkn; bus.br_offset = vt[i].off;
      step();
      chk($sformatf("r%0d_req", i),    {31'h0, bus.imem_req},    {31'h0, vt[i].e_req});
      chk($sformatf("r%0d_addr", i),   {23'h0, bus.imem_addr},   {23'h0, vt[i].e_addr});
      chk($sformatf("r%0d_valid", i),  {31'h0, bus.instr_valid}, {31'h0, vt[i].e_vld});
      chk($sformatf("r%0d_busy", i),   {31'h0, busy},            {31'h0, vt[i].e_busy});
      chk($sformatf("r%0d_halted", i), {31'h0, halted},          {31'h0, vt[i].e_hltd});
      chk($sformatf("r%0d_ret", i),    {16'h0, retired},         {16'h0, vt[i].e_ret});
      chk($sformatf("r%0d_ret_sat", i), {30'h0, retired2},
          (vt[i].e_ret > 16'd3) ? 32'd3 : {16'h0, vt[i].e_ret});
      chk($sformatf("r%0d_req_vld_excl", i), {31'h0, bus.imem_req & bus.instr_valid}, 32'h0);
      if (vt[i].e_vld) begin
        chk($sformatf("r%0d_instr", i), bus.instr,             vt[i].e_ins);
        chk($sformatf("r%0d_ipc", i),   {23'h0, bus.instr_pc}, {23'h0, vt[i].e_ipc});
      end
    end
    idle_inputs();

    // Halt coincident with imem_ack: data dropped, start ignored afterwards.
    rst = 1'b1;
    #2;
    chk("hA_rst_halted", {31'h0, halted}, 32'h0);
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hA_req", {31'h0, bus.imem_req}, 32'h1);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h13; halt = 1'b1;
    step();
    idle_inputs();
    chk("hA_halted", {31'h0, halted},          32'h1);
    chk("hA_valid",  {31'h0, bus.instr_valid}, 32'h0);
    chk("hA_req0",   {31'h0, bus.imem_req},    32'h0);
    chk("hA_busy",   {31'h0, busy},            32'h0);
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    chk("hA_st_halted", {31'h0, halted},          32'h1);
    chk("hA_st_valid",  {31'h0, bus.instr_valid}, 32'h0);
    chk("hA_st_req",    {31'h0, bus.imem_req},    32'h0);
    chk("hA_st_ret",    {16'h0, retired},         32'h0);

    // Asynchronous reset while waiting on a branch.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'h63;
    step();
    bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    chk("hB_brwait_busy", {31'h0, busy},         32'h1);
    chk("hB_brwait_req",  {31'h0, bus.imem_req}, 32'h0);
    chk("hB_brwait_ret",  {16'h0, retired},      32'h1);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk_all_zero("hB_async");
    #1;
    rst = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("hB_restart_req",  {31'h0, bus.imem_req},  32'h1);
    chk("hB_restart_addr", {23'h0, bus.imem_addr}, 32'h0);
    chk("hB_restart_busy", {31'h0, busy},          32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle fetch controller that owns the program counter. It sequences instruction-memory reads and hands each fetched instruction to the execute stage over a valid/ready handshake. It stalls on conditional branches until execute resolves them, then redirects the PC. It sits between instruction memory and the execute/decode stage.

Parameters:
PC_W, 9, PC width in bits; PC is word-addressed and increments by 1.
INSTR_W, 32, instruction width.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle pulse; begins fetching at PC 0 (ignored outside IDLE)
imem_req  output  1  instruction-memory read request
imem_addr  output  PC_W  read address (current PC)
imem_ack  input  1  read data valid this cycle
imem_rdata  input  INSTR_W  read data
instr_valid  output  1  fetched instruction available
instr  output  INSTR_W  fetched instruction
instr_pc  output  PC_W  PC of the fetched instruction
instr_ready  input  1  execute accepts instruction
br_resolve  input  1  branch outcome valid
br_taken  input  1  branch taken
br_offset  input  PC_W  two's-complement word offset, relative to instr_pc
halt  input  1  stop fetching
busy  output  1  high in FETCH, ISSUE or BRWAIT
halted  output  1  high in HALTED
retired  output  CNT_W  count of instructions accepted by execute; saturating

Behaviour:
- Reset: state=IDLE; pc, instr, instr_pc, retired = 0; all 1-bit outputs = 0.
- IDLE: outputs idle. start=1 moves to FETCH with pc=0.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack.
  - On the ack edge: instr<=imem_rdata, instr_pc<=pc, go to ISSUE.
  - instr_valid rises the cycle after ack; minimum ack-to-valid latency is 1 cycle.
- ISSUE:
  - instr_valid=1; instr and instr_pc held stable while instr_ready=0.
  - On instr_ready: retired increments, saturating at all-ones.
  - If instr[6:0]==OPC_BRANCH (7'b1100011), go to BRWAIT.
  - Otherwise pc<=pc+1 and go to FETCH.
- BRWAIT:
  - No request; waits for br_resolve.
  - On resolve: taken gives pc<=instr_pc+br_offset; not taken gives pc<=instr_pc+1. Go to FETCH.
- br_resolve is ignored in every state other than BRWAIT.
- HALTED: all request/valid outputs 0; halted=1; exits only on rst.
- halt has priority over every other event in FETCH, ISSUE and BRWAIT; it is ignored in IDLE.
  - halt with imem_ack in the same cycle: data dropped, go to HALTED.
  - halt with instr_ready in the same cycle: the instruction is not retired.
- Arithmetic: all PC sums are modulo 2^PC_W; 511+1 wraps to 0. Negative offsets use two's complement.
- One instruction in flight at a time; no prefetch.
- imem_req and instr_valid are never high in the same cycle.
- Reset mid-operation: immediate return to reset values. Any pending memory response is the memory's responsibility to discard.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, FETCH, ISSUE, BRWAIT, HALTED}
  - OPC_BRANCH constant
  - default PC_W, INSTR_W
- One sub-module: fetch_pc_next, combinational next-PC select (hold / +1 / instr_pc+1 / instr_pc+offset).
- FSM, PC register and retired counter stay in the top.

Test Plan:
- Basic fetch: rst, start; imem_ack 2 cycles later with 32'h00000013 -> instr_valid next cycle, instr_pc=0; instr_ready -> imem_addr=1, retired=1.
- Backpressure: instr_ready low 5 cycles -> instr, instr_pc stable, imem_req=0 throughout; retired increments once on accept.
- Taken branch: 32'h00000063 at pc 4, br_resolve+br_taken, br_offset=9'h1FC -> next imem_addr=0. Not taken -> next imem_addr=5. br_resolve pulsed in FETCH -> no effect.
- Wrap: non-branch at pc 511 accepted -> imem_addr=0. retired preloaded to 16'hFFFF -> stays 16'hFFFF.
- Halt: halt with imem_ack in the same cycle -> halted=1, instr_valid never rises, imem_req=0. start afterwards -> ignored.
- Reset mid-BRWAIT: assert rst asynchronously -> all outputs 0 before the next clk edge; state IDLE; start restarts at pc 0.
